// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - arbitrates the instruction ROM read port between IF and DBG, 1-cycle registered response.
// Define ROM_ARB_RR_EN for round-robin; otherwise fixed IF priority with a DBG starvation guard.
module rom_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              dbg_req,
  input  logic [31:0]       dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_err,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  logic              if_win;
  logic              dbg_win;
  logic [31:0]       sel_addr;
  logic              fault;
  logic [DATA_W-1:0] resp_data;

  logic              if_rvalid_q, dbg_rvalid_q;
  logic              if_err_q, dbg_err_q;
  logic [DATA_W-1:0] if_rdata_q, dbg_rdata_q;

`ifdef ROM_ARB_RR_EN
  // rr_ptr_q: last contended winner, 1 = DBG
  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    if_win   = if_req && (!dbg_req || rr_ptr_q);
    dbg_win  = dbg_req && !if_win;
    rr_ptr_d = (if_req && dbg_req) ? dbg_win : rr_ptr_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_ptr_q <= 1'b1;
    else        rr_ptr_q <= rr_ptr_d;
  end
`else
  localparam logic [0:0] NORMAL     = 1'b0;
  localparam logic [0:0] FORCE_DBG  = 1'b1;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [0:0] state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    dbg_win = dbg_req && (!if_req || (state_q == FORCE_DBG));
    if_win  = if_req && !dbg_win;
    starve_cnt_d = 4'd0;
    if (dbg_req && !dbg_win)
      starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? starve_cnt_q : starve_cnt_q + 4'd1;
    // Enter FORCE_DBG as the count reaches the limit so DBG wins in cycle STARVE_MAX+1
    state_d = NORMAL;
    if ((state_q == NORMAL) && (starve_cnt_d == STARVE_LIM))
      state_d = FORCE_DBG;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= NORMAL;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end
`endif

  assign if_gnt    = reset && if_win;
  assign dbg_gnt   = reset && dbg_win;
  assign sel_addr  = dbg_win ? dbg_addr : if_addr;
  assign fault     = (sel_addr[1:0] != 2'b00) || (sel_addr[31:ADDR_W+2] != '0);
  assign resp_data = fault ? '0 : rom_data;
  assign rom_addr  = (if_gnt || dbg_gnt) ? sel_addr[ADDR_W+1:2] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_rvalid_q  <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      if_err_q     <= 1'b0;
      dbg_err_q    <= 1'b0;
      if_rdata_q   <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      if_rvalid_q  <= if_win;
      dbg_rvalid_q <= dbg_win;
      if (if_win) begin
        if_rdata_q <= resp_data;
        if_err_q   <= fault;
      end
      if (dbg_win) begin
        dbg_rdata_q <= resp_data;
        dbg_err_q   <= fault;
      end
    end
  end

  assign if_rvalid  = if_rvalid_q;
  assign if_rdata   = if_rdata_q;
  assign if_err     = if_err_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign dbg_err    = dbg_err_q;

endmodule
